// File: rtl/shift_pass_sequencer_if.sv
// Handshake bundle for shift_pass_sequencer: command in, shifter drive/feedback, result out.
// SHIFT_SEQ_OVERSHIFT_EN widens in_shift_amount by one bit so amounts >= DATA_W can be requested.
interface shift_pass_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5,
    parameter int STEP_W = 4
);
`ifdef SHIFT_SEQ_OVERSHIFT_EN
    localparam int AMT_PORT_W = AMT_W + 1;
`else
    localparam int AMT_PORT_W = AMT_W;
`endif

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic                  in_is_shift_right;
    logic [AMT_PORT_W-1:0] in_shift_amount;

    logic [DATA_W-1:0]     sh_data;
    logic                  sh_is_shift_right;
    logic [STEP_W-1:0]     sh_shift_value;
    logic [DATA_W-1:0]     sh_shifted_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic                  out_is_shift_right;

    // slave: the sequencer itself; master: the surrounding upstream/shifter/downstream logic
    modport slave (
        input  in_valid, in_data, in_is_shift_right, in_shift_amount,
        input  sh_shifted_data, out_ready,
        output in_ready, sh_data, sh_is_shift_right, sh_shift_value,
        output out_valid, out_data, out_is_shift_right
    );

    modport master (
        output in_valid, in_data, in_is_shift_right, in_shift_amount,
        output sh_shifted_data, out_ready,
        input  in_ready, sh_data, sh_is_shift_right, sh_shift_value,
        input  out_valid, out_data, out_is_shift_right
    );
endinterface

// File: rtl/shift_pass_sequencer.sv
// Splits 0..31 shift commands into passes of at most STEP_MAX for a 4-bit barrel shifter.
// Optional SHIFT_SEQ_OVERSHIFT_EN: amounts >= DATA_W complete immediately with a zero result.
module shift_pass_sequencer #(
    parameter int DATA_W      = 32,
    parameter int AMT_W       = 5,
    parameter int STEP_MAX    = 15,
    parameter int STEP_W      = 4,
    parameter int SHIFTER_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    shift_pass_sequencer_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int LAT_W = (SHIFTER_LAT < 2) ? 1 : $clog2(SHIFTER_LAT + 1);

    logic [1:0]        state_reg;
    logic [DATA_W-1:0] work_reg;
    logic              dir_reg;
    logic [AMT_W-1:0]  rem_reg;
    logic [LAT_W-1:0]  lat_reg;
    logic [DATA_W-1:0] sh_data_reg;
    logic              sh_dir_reg;
    logic [STEP_W-1:0] sh_val_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_dir_reg;

    logic              accept;
    logic              zero_amt;
    logic              over_amt;
    logic [STEP_W-1:0] step;

    assign accept   = bus.in_valid && (state_reg == S_IDLE);
    assign zero_amt = (bus.in_shift_amount == '0);

`ifdef SHIFT_SEQ_OVERSHIFT_EN
    localparam logic [AMT_W:0] DATA_W_AMT = DATA_W[AMT_W:0];
    assign over_amt = (bus.in_shift_amount >= DATA_W_AMT);
`else
    assign over_amt = 1'b0;
`endif

    always_comb begin
        step = rem_reg[STEP_W-1:0];
        if (rem_reg > AMT_W'(STEP_MAX))
            step = STEP_W'(STEP_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            work_reg     <= '0;
            dir_reg      <= 1'b0;
            rem_reg      <= '0;
            lat_reg      <= '0;
            sh_data_reg  <= '0;
            sh_dir_reg   <= 1'b0;
            sh_val_reg   <= '0;
            out_data_reg <= '0;
            out_dir_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        work_reg <= bus.in_data;
                        dir_reg  <= bus.in_is_shift_right;
                        rem_reg  <= bus.in_shift_amount[AMT_W-1:0];
                        if (over_amt) begin
                            // everything shifts out: answer without touching the shifter
                            out_data_reg <= '0;
                            out_dir_reg  <= bus.in_is_shift_right;
                            state_reg    <= S_DONE;
                        end else if (zero_amt) begin
                            out_data_reg <= bus.in_data;
                            out_dir_reg  <= bus.in_is_shift_right;
                            state_reg    <= S_DONE;
                        end else begin
                            state_reg <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    sh_data_reg <= work_reg;
                    sh_dir_reg  <= dir_reg;
                    sh_val_reg  <= step;
                    rem_reg     <= rem_reg - AMT_W'(step);
                    lat_reg     <= LAT_W'(SHIFTER_LAT);
                    state_reg   <= S_WAIT;
                end
                S_WAIT: begin
                    lat_reg <= lat_reg - LAT_W'(1);
                    if (lat_reg == LAT_W'(1)) begin
                        work_reg <= bus.sh_shifted_data;
                        if (rem_reg == '0) begin
                            out_data_reg <= bus.sh_shifted_data;
                            out_dir_reg  <= dir_reg;
                            sh_val_reg   <= '0;
                            state_reg    <= S_DONE;
                        end else begin
                            state_reg <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        sh_val_reg <= '0;
                        state_reg  <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready           = (state_reg == S_IDLE);
    assign bus.out_valid          = (state_reg == S_DONE);
    assign bus.out_data           = out_data_reg;
    assign bus.out_is_shift_right = out_dir_reg;
    assign bus.sh_data            = sh_data_reg;
    assign bus.sh_is_shift_right  = sh_dir_reg;
    assign bus.sh_shift_value     = sh_val_reg;
endmodule
